// File: rtl/mlp_infer_pkg.sv
// Shared types and helpers for the two-layer MLP inference engine.
// Optional accumulator saturation is selected with the MLP_INFER_SAT_EN macro.
package mlp_infer_pkg;

    typedef enum logic [1:0] {L1, L2, ARG, DONE} state_t;

    // Widths for the reference 784-32-10 build; the top recomputes them from its own parameters.
    localparam int ROW_W = $clog2(784 + 32);
    localparam int CLS_W = $clog2(10);

    // Adds two sign-extended operands and clamps the sum to the signed range of acc_w bits.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int unsigned        acc_w,
        output logic               sat
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = 1'b0;
        if (sum > hi) begin
            sum = hi;
            sat = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            sat = 1'b1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mlp_infer_engine_mac_lane.sv
// One signed multiply-accumulate lane with clear/enable; saturates when MLP_INFER_SAT_EN is defined.
// Clear and enable together load the product into a zeroed accumulator.
module mlp_mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
`ifdef MLP_INFER_SAT_EN
    ,
    output logic                     sat
`endif
);
    import mlp_infer_pkg::*;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    acc_nxt;
`ifdef MLP_INFER_SAT_EN
    logic signed [63:0]         sum64;
`endif

    always_comb begin
        prod   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        base   = clr ? '0 : acc;
        addend = en ? ACC_W'(prod) : '0;
`ifdef MLP_INFER_SAT_EN
        sat     = 1'b0;
        sum64   = sat_add(64'(base), 64'(addend), ACC_W, sat);
        acc_nxt = sum64[ACC_W-1:0];
`else
        acc_nxt = base + addend;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clr || en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/mlp_infer_engine.sv
// Two-layer fully-connected inference engine: streamed layer 1, ReLU/requantise, layer 2, argmax.
// Define MLP_INFER_SAT_EN for saturating accumulators with a sticky flag in dbg_reg[0].
module mlp_infer_engine #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 8,
    localparam int ROW_W = $clog2(N_IN + N_HID),
    localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic [ROW_W-1:0]          wt_addr,
    input  logic [N_HID*DATA_W-1:0]   wt_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [CLS_W-1:0]          res_class,
    output logic signed [ACC_W-1:0]   res_score
);
    import mlp_infer_pkg::*;

    localparam logic signed [DATA_W-1:0] QMAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_t                    state, state_nxt;
    logic [ROW_W-1:0]          row, row_nxt;
    logic                      primed;
    logic                      fire;
    logic                      in_l1, in_l2, done_hs;

    logic signed [ACC_W-1:0]   lane_acc [N_HID];
    logic signed [DATA_W-1:0]  lane_a   [N_HID];
    logic signed [DATA_W-1:0]  lane_b   [N_HID];
    logic [N_HID-1:0]          lane_en;
    logic [N_HID-1:0]          lane_clr;

    logic signed [DATA_W-1:0]  hq    [N_HID];
    logic signed [DATA_W-1:0]  q_all [N_HID];
    logic signed [DATA_W-1:0]  q_cur;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   o_sel;
    logic signed [ACC_W-1:0]   best_score;
    logic [CLS_W-1:0]          best_cls;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= L1;
            row    <= '0;
            primed <= 1'b0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            primed <= (state == L1) && (state_nxt == L1);
        end
    end

    always_comb begin
        in_l1     = (state == L1);
        in_l2     = (state == L2);
        in_ready  = in_l1 && primed;
        fire      = in_valid && in_ready;
        res_valid = (state == DONE);
        done_hs   = res_valid && res_ready;
        state_nxt = state;
        row_nxt   = row;
        case (state)
            L1: begin
                if (fire) begin
                    if (row == ROW_W'(N_IN - 1)) begin
                        row_nxt   = '0;
                        state_nxt = L2;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
            end
            L2: begin
                if (row == ROW_W'(N_HID - 1)) begin
                    row_nxt   = '0;
                    state_nxt = ARG;
                end else begin
                    row_nxt = row + 1'b1;
                end
            end
            ARG: begin
                if (row == ROW_W'(N_OUT - 1)) begin
                    row_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    row_nxt = row + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    row_nxt   = '0;
                    state_nxt = L1;
                end
            end
            default: begin
                row_nxt   = '0;
                state_nxt = L1;
            end
        endcase
    end

    // The row after the current one is always requested so ROM latency is hidden.
    assign wt_addr = (in_l2 ? ROW_W'(N_IN) : '0) + row + ROW_W'(fire || in_l2);

    always_comb begin
        shifted = '0;
        for (int unsigned k = 0; k < N_HID; k++) begin
            shifted = lane_acc[k] >>> SHIFT;
            if (lane_acc[k] < 0) begin
                q_all[k] = '0;
            end else if (shifted > ACC_W'(QMAX)) begin
                q_all[k] = QMAX;
            end else begin
                q_all[k] = shifted[DATA_W-1:0];
            end
        end
    end

    // Lanes 0..N_OUT-1 are overwritten by o[] from the first L2 row, so the requantised
    // hidden values are snapshotted into hq[] on that row; row 0 uses the live value.
    always_comb begin
        q_cur = q_all[0];
        for (int unsigned k = 1; k < N_HID; k++) begin
            if (row == ROW_W'(k)) begin
                q_cur = hq[k];
            end
        end
        o_sel = lane_acc[0];
        for (int unsigned k = 1; k < N_OUT; k++) begin
            if (row == ROW_W'(k)) begin
                o_sel = lane_acc[k];
            end
        end
        for (int unsigned k = 0; k < N_HID; k++) begin
            lane_a[k]   = in_l1 ? in_data : q_cur;
            lane_b[k]   = wt_data[k*DATA_W +: DATA_W];
            lane_en[k]  = fire || (in_l2 && (k < N_OUT));
            lane_clr[k] = done_hs || (in_l2 && (row == '0) && (k < N_OUT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_score <= '0;
            best_cls   <= '0;
            for (int unsigned k = 0; k < N_HID; k++) begin
                hq[k] <= '0;
            end
        end else begin
            if (in_l2 && (row == '0)) begin
                for (int unsigned k = 0; k < N_HID; k++) begin
                    hq[k] <= q_all[k];
                end
            end
            if ((state == ARG) && ((row == '0) || (o_sel > best_score))) begin
                best_score <= o_sel;
                best_cls   <= row[CLS_W-1:0];
            end
        end
    end

    assign res_class = best_cls;
    assign res_score = best_score;

`ifdef MLP_INFER_SAT_EN
    logic [N_HID-1:0] lane_sat;
    logic [7:0]       dbg_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_reg <= '0;
        end else begin
            dbg_reg[0] <= dbg_reg[0] | (|lane_sat);
        end
    end
`endif

    for (genvar k = 0; k < N_HID; k++) begin : g_lane
        mlp_mac_lane #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .clr  (lane_clr[k]),
            .en   (lane_en[k]),
            .a    (lane_a[k]),
            .b    (lane_b[k]),
            .acc  (lane_acc[k])
`ifdef MLP_INFER_SAT_EN
            ,
            .sat  (lane_sat[k])
`endif
        );
    end

endmodule

// File: tb/tb_mlp_infer_engine.sv
// Directed bench for mlp_infer_engine at N_IN=4, N_HID=3, N_OUT=2, ACC_W=16, SHIFT=0.
// Expected overflow result follows MLP_INFER_SAT_EN.
module tb_mlp_infer_engine;

    localparam int N_IN   = 4;
    localparam int N_HID  = 3;
    localparam int N_OUT  = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int SHIFT  = 0;
    localparam int LAT    = N_HID + N_OUT + 1;
    localparam int NVEC   = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic [2:0]         wt_addr;
    logic [23:0]        wt_data;
    logic               res_valid;
    logic               res_ready;
    logic [0:0]         res_class;
    logic signed [15:0] res_score;
    logic [23:0]        rom [8];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0][7:0]    pix;
        logic [7:0][23:0]   img;
        logic [0:0]         cls;
        logic signed [15:0] score;
    } vec_t;

    vec_t vecs [NVEC];

    mlp_infer_engine #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .N_OUT (N_OUT),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_class(res_class),
        .res_score(res_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) wt_data <= rom[wt_addr];

    function automatic logic [23:0] r3(input int l0, input int l1, input int l2);
        return {8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic logic [3:0][7:0] px4(input int p0, input int p1, input int p2, input int p3);
        logic [3:0][7:0] p;
        p[0] = 8'(p0);
        p[1] = 8'(p1);
        p[2] = 8'(p2);
        p[3] = 8'(p3);
        return p;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_pixels(input logic [3:0][7:0] p, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            in_valid = 1'b1;
            in_data  = p[i];
            while (!in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL pixel_wait: in_ready=0 after %0d cycles, expected 1", w);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic start_and_wait(input vec_t v, input string tag);
        int lat;
        for (int r = 0; r < 8; r++) rom[r] = v.img[r];
        send_pixels(v.pix, N_IN);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".class"}, res_class, v.cls);
        check({tag, ".score"}, $signed(res_score), $signed(v.score));
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, ".valid_drop"}, res_valid, 0);
        check({tag, ".prefetch_bubble"}, in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;

        // h=10 per lane, o={30,60}
        vecs[0].pix = px4(1, 2, 3, 4);
        for (int r = 0; r < 4; r++) vecs[0].img[r] = r3(1, 1, 1);
        for (int r = 4; r < 7; r++) vecs[0].img[r] = r3(1, 2, 85);
        vecs[0].img[7] = r3(9, 9, 9);
        vecs[0].cls = 1'b1;  vecs[0].score = 16'sd60;

        // h={-5,200,0} -> q={0,127,0}, o={127,-127}
        vecs[1].pix = px4(1, 1, 1, 1);
        vecs[1].img[0] = r3(-5, 100, 0);
        vecs[1].img[1] = r3(0, 100, 0);
        vecs[1].img[4] = r3(1, 2, 85);
        vecs[1].img[5] = r3(1, -1, 85);
        vecs[1].img[6] = r3(1, 2, 85);
        vecs[1].cls = 1'b0;  vecs[1].score = 16'sd127;

        // o={7,7}: tie keeps the lower index
        vecs[2].pix = px4(1, 0, 0, 0);
        vecs[2].img[0] = r3(7, 0, 0);
        for (int r = 1; r < 4; r++) vecs[2].img[r] = r3(50, 50, 50);
        vecs[2].img[4] = r3(1, 1, 0);
        vecs[2].img[5] = r3(3, 4, 0);
        vecs[2].img[6] = r3(5, 6, 0);
        vecs[2].cls = 1'b0;  vecs[2].score = 16'sd7;

        // o={-3,-1}: all-negative scores, winner is class 1
        vecs[3].pix = px4(1, 0, 0, 0);
        vecs[3].img[0] = r3(1, 0, 0);
        for (int r = 1; r < 4; r++) vecs[3].img[r] = r3(20, 20, 20);
        vecs[3].img[4] = r3(-3, -1, 0);
        vecs[3].img[5] = r3(5, 5, 0);
        vecs[3].img[6] = r3(5, 5, 0);
        vecs[3].cls = 1'b1;  vecs[3].score = -16'sd1;

        // h0 = 16129+16129+510 = 32768 overflows ACC_W=16
        vecs[4].pix = px4(127, 127, 5, 0);
        vecs[4].img[0] = r3(127, 0, 0);
        vecs[4].img[1] = r3(127, 0, 0);
        vecs[4].img[2] = r3(102, 0, 0);
        for (int r = 4; r < 7; r++) vecs[4].img[r] = r3(1, 0, 0);
        vecs[4].cls = 1'b0;
`ifdef MLP_INFER_SAT_EN
        vecs[4].score = 16'sd127;
`else
        vecs[4].score = 16'sd0;
`endif

        // h={127,128,-1} -> q={127,127,0}, o={127,-127}
        vecs[5].pix = px4(1, 1, 0, 0);
        vecs[5].img[0] = r3(127, 64, -1);
        vecs[5].img[1] = r3(0, 64, 0);
        vecs[5].img[2] = r3(33, 33, 33);
        vecs[5].img[3] = r3(33, 33, 33);
        vecs[5].img[4] = r3(1, 0, 0);
        vecs[5].img[5] = r3(0, -1, 0);
        vecs[5].img[6] = r3(9, 9, 0);
        vecs[5].cls = 1'b0;  vecs[5].score = 16'sd127;

        for (int r = 0; r < 8; r++) rom[r] = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 0);
        check("reset.res_valid", res_valid, 0);
        check("reset.res_class", res_class, 0);
        check("reset.res_score", $signed(res_score), 0);
        check("reset.wt_addr", wt_addr, 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            start_and_wait(vecs[i], $sformatf("vec%0d", i));
            take_result($sformatf("vec%0d", i));
        end

        // Backpressure: result held, pixels ignored
        start_and_wait(vecs[0], "bp");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'sd55;
            @(posedge clk); #1;
            check($sformatf("bp%0d.res_valid", c), res_valid, 1);
            check($sformatf("bp%0d.res_class", c), res_class, 1);
            check($sformatf("bp%0d.res_score", c), $signed(res_score), 60);
            check($sformatf("bp%0d.in_ready", c), in_ready, 0);
        end
        in_valid = 1'b0;
        take_result("bp");
        start_and_wait(vecs[2], "bp_next");
        take_result("bp_next");

        // Reset after two pixels discards the partial sums
        for (int r = 0; r < 8; r++) rom[r] = vecs[0].img[r];
        send_pixels(vecs[0].pix, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst.wt_addr", wt_addr, 0);
        check("midrst.in_ready", in_ready, 0);
        check("midrst.res_valid", res_valid, 0);
        start_and_wait(vecs[0], "midrst");
        take_result("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
